buffer_filler: RTL and testbench
================================

BUFFER_FILLER -- requirements
Module: buffer_filler

Interface
REQ-001 The block SHALL take its buffer geometry constants from the shared buffer constants: BUFFER_SIZE_BYTES (default 512) = bytes per half-buffer, BUFFER_ADDR_BITS (default 9) = address width.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 start_i  in  1  single-cycle pulse that begins streaming a new file; honoured only in IDLE or DONE.
REQ-005 abort_i  in  1  single-cycle pulse that stops streaming and returns the block to IDLE.
REQ-006 s_data_i  in  8  PCM byte from the file reader.
REQ-007 s_valid_i  in  1  s_data_i is valid.
REQ-008 s_last_i  in  1  qualifies the final byte of the file.
REQ-009 s_ready_o  out  1  block accepts a byte this cycle; a byte transfers when s_valid_i && s_ready_o.
REQ-010 ram_we_o  out  1  half-buffer RAM write enable.
REQ-011 ram_sel_o  out  1  half-buffer being written.
REQ-012 ram_addr_o  out  BUFFER_ADDR_BITS  write address.
REQ-013 ram_data_o  out  8  write data.
REQ-014 codec_buffer_filled_o  out  1  the written half-buffer is complete and available to the consumer.
REQ-015 codec_buffer_empty_i  in  1  the consumer has released a half-buffer.
REQ-016 codec_buffer_empty_ack_o  out  1  single-cycle acknowledge of codec_buffer_empty_i.
REQ-017 done_o  out  1  the last buffer of the file has been handed to the consumer.

Function
REQ-018 The FSM SHALL have four states: IDLE, FILL, PAD and FULL, plus a DONE state.
REQ-019 IDLE: s_ready_o=0; when codec_buffer_empty_i=1, codec_buffer_empty_ack_o SHALL pulse for one cycle (start-up release); codec_buffer_filled_o is unchanged.
REQ-020 IDLE to FILL on start_i: wr_sel=1, addr=0.
REQ-021 FILL: s_ready_o=1; on each transfer, write s_data_i at {wr_sel, addr} with ram_we_o=1 in the same cycle (zero latency), then addr+1.
REQ-022 FILL, transfer at addr=BUFFER_SIZE_BYTES-1: go to FULL and set codec_buffer_filled_o=1 on the next cycle.
REQ-023 FILL, transfer with s_last_i=1 and addr<BUFFER_SIZE_BYTES-1: set eof=1 and go to PAD.
REQ-024 If s_last_i coincides with addr=BUFFER_SIZE_BYTES-1, the block SHALL set eof=1 and go directly to FULL.
REQ-025 PAD: s_ready_o=0; write 0x00 with ram_we_o=1 at each successive address, one per cycle, through BUFFER_SIZE_BYTES-1, then go to FULL with codec_buffer_filled_o=1.
REQ-026 FULL: s_ready_o=0 and ram_we_o=0; wait for codec_buffer_empty_i=1.
REQ-027 FULL, on codec_buffer_empty_i=1: pulse codec_buffer_empty_ack_o for one cycle, clear codec_buffer_filled_o, toggle wr_sel, clear addr, then go to FILL (eof=0) or DONE (eof=1).
REQ-028 codec_buffer_empty_i SHALL be ignored in any cycle where codec_buffer_empty_ack_o=1, so that one release is never acknowledged twice.
REQ-029 codec_buffer_empty_i asserted in FILL or PAD SHALL NOT be acknowledged until FULL.
REQ-030 DONE: done_o=1, s_ready_o=0; start_i goes to FILL with wr_sel toggled and addr=0, clears done_o and eof, and leaves codec_buffer_filled_o at 0.
REQ-031 abort_i in any state SHALL, next cycle, clear codec_buffer_filled_o, codec_buffer_empty_ack_o, ram_we_o, s_ready_o, done_o and eof, and go to IDLE; abort_i takes priority over start_i and over transfers.
REQ-032 ram_sel_o SHALL equal wr_sel and ram_addr_o SHALL equal addr at all times.
REQ-033 addr arithmetic is modulo 2^BUFFER_ADDR_BITS, but addr SHALL never increment past BUFFER_SIZE_BYTES-1.
REQ-034 In every state, s_ready_o=0 SHALL imply ram_we_o is driven only by PAD.

Reset
REQ-035 While rst_n=0 at a clk edge: state=IDLE, wr_sel=1, addr=0, eof=0; all outputs 0 except ram_sel_o=1.
REQ-036 Reset mid-FILL or mid-FULL SHALL drop codec_buffer_filled_o within one cycle, with no write issued in that cycle.

Structure
REQ-037 BUFFER_SIZE_BYTES and BUFFER_ADDR_BITS SHALL come from the shared buffer constants include; FSM state encodings are local.
REQ-038 The block SHALL be a single module with no sub-modules.

Verification
REQ-039 Start-up: empty_i=1 in IDLE -> exactly one ack pulse; start_i, then 512 bytes -> filled_o=1, writes to sel=1 at addresses 0..511 in order.
REQ-040 Swap: in FULL, raise empty_i for 2 cycles -> one ack pulse, filled_o=0, ram_sel_o=0, addr=0, s_ready_o=1 next cycle.
REQ-041 Short file: 100 bytes with s_last_i on byte 100 -> addresses 100..511 written 0x00 over 412 cycles; filled_o=1; after ack, done_o=1.
REQ-042 Backpressure: s_valid_i toggling at random -> no write when s_valid_i=0, RAM contents match the byte sequence.
REQ-043 Boundary: s_last_i at addr 511 -> no PAD cycles, direct FULL, then DONE after ack.
REQ-044 Abort mid-FILL at addr 37 -> next cycle state IDLE, filled_o=0, s_ready_o=0, no further writes.

Source files
------------

// File: rtl/buffer_filler_pkg.sv
// Shared buffer constants for the half-buffer streaming path.
//   BUFFER_SIZE_BYTES : bytes held by one half-buffer
//   BUFFER_ADDR_BITS  : width of a byte address inside one half-buffer
//   BUFFER_LAST_ADDR  : address of the final byte of a half-buffer
package buffer_filler_pkg;

  localparam int BUFFER_SIZE_BYTES = 512;
  localparam int BUFFER_ADDR_BITS  = 9;

  localparam logic [BUFFER_ADDR_BITS-1:0] BUFFER_LAST_ADDR =
    BUFFER_ADDR_BITS'(BUFFER_SIZE_BYTES - 1);

endpackage

// File: rtl/buffer_filler.sv
// buffer_filler: streams PCM bytes from the file reader into a ping-pong
// pair of half-buffers and hands each completed half to the codec.
// A short final half is padded with 0x00 so the codec always consumes a
// full half-buffer.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   start_i, abort_i           begin streaming a file / drop back to IDLE
//   s_data_i/s_valid_i/
//   s_last_i/s_ready_o         byte stream from the file reader
//   ram_we_o/ram_sel_o/
//   ram_addr_o/ram_data_o      write port of the half-buffer RAM
//   codec_buffer_filled_o      current half-buffer is complete
//   codec_buffer_empty_i       codec released a half-buffer
//   codec_buffer_empty_ack_o   one-cycle acknowledge of that release
//   done_o                     last half-buffer of the file handed over
module buffer_filler
  import buffer_filler_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic [7:0]                  s_data_i,
  input  logic                        s_valid_i,
  input  logic                        s_last_i,
  output logic                        s_ready_o,
  output logic                        ram_we_o,
  output logic                        ram_sel_o,
  output logic [BUFFER_ADDR_BITS-1:0] ram_addr_o,
  output logic [7:0]                  ram_data_o,
  output logic                        codec_buffer_filled_o,
  input  logic                        codec_buffer_empty_i,
  output logic                        codec_buffer_empty_ack_o,
  output logic                        done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_FULL,
    ST_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic                        wr_sel_q, wr_sel_d;
  logic [BUFFER_ADDR_BITS-1:0] addr_q, addr_d;
  logic                        eof_q, eof_d;
  logic                        filled_q, filled_d;
  logic                        ack_q, ack_d;
  logic                        done_q, done_d;

  // Abort and reset both win over a transfer in the same cycle, so the
  // write port and ready are masked combinationally by them.
  logic live;
  logic fill_ready;
  logic xfer;
  logic pad_we;
  logic at_last;
  logic empty_seen;

  assign live       = rst_n && !abort_i;
  assign fill_ready = (state_q == ST_FILL) && live;
  assign xfer       = fill_ready && s_valid_i;
  assign pad_we     = (state_q == ST_PAD) && live;
  assign at_last    = (addr_q == BUFFER_LAST_ADDR);
  // A release arriving while the previous one is still being acknowledged
  // is the same release held high; ignore it.
  assign empty_seen = codec_buffer_empty_i && !ack_q;

  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    addr_d   = addr_q;
    eof_d    = eof_q;
    filled_d = filled_q;
    ack_d    = 1'b0;
    done_d   = done_q;

    if (abort_i) begin
      state_d  = ST_IDLE;
      eof_d    = 1'b0;
      filled_d = 1'b0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Start-up release: the codec frees its initial buffer before
          // any file is streamed.
          if (empty_seen) ack_d = 1'b1;
          if (start_i) begin
            state_d  = ST_FILL;
            wr_sel_d = 1'b1;
            addr_d   = '0;
            eof_d    = 1'b0;
          end
        end

        ST_FILL: begin
          if (xfer) begin
            if (at_last) begin
              // Last byte of the half fills it exactly: no padding needed
              // even when it is also the last byte of the file.
              state_d  = ST_FULL;
              filled_d = 1'b1;
              if (s_last_i) eof_d = 1'b1;
            end else begin
              addr_d = addr_q + 1'b1;
              if (s_last_i) begin
                eof_d   = 1'b1;
                state_d = ST_PAD;
              end
            end
          end
        end

        ST_PAD: begin
          if (at_last) begin
            state_d  = ST_FULL;
            filled_d = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end

        ST_FULL: begin
          if (empty_seen) begin
            ack_d    = 1'b1;
            filled_d = 1'b0;
            wr_sel_d = !wr_sel_q;
            addr_d   = '0;
            state_d  = eof_q ? ST_DONE : ST_FILL;
            done_d   = eof_q;
          end
        end

        ST_DONE: begin
          if (start_i) begin
            state_d  = ST_FILL;
            wr_sel_d = !wr_sel_q;
            addr_d   = '0;
            eof_d    = 1'b0;
            done_d   = 1'b0;
            filled_d = 1'b0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_sel_q <= 1'b1;
      addr_q   <= '0;
      eof_q    <= 1'b0;
      filled_q <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      addr_q   <= addr_d;
      eof_q    <= eof_d;
      filled_q <= filled_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end

  assign s_ready_o                = fill_ready;
  assign ram_we_o                 = xfer || pad_we;
  assign ram_sel_o                = wr_sel_q;
  assign ram_addr_o               = addr_q;
  assign ram_data_o               = fill_ready ? s_data_i : 8'h00;
  assign codec_buffer_filled_o    = filled_q;
  assign codec_buffer_empty_ack_o = ack_q;
  assign done_o                   = done_q;

endmodule

// File: tb/tb_buffer_filler.sv
// Directed bench for buffer_filler: start-up release, full fill, swap,
// short file with padding under backpressure, exact-boundary end of file,
// abort and reset in the middle of a transfer.
module tb_buffer_filler;
  import buffer_filler_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        start_i;
  logic                        abort_i;
  logic [7:0]                  s_data_i;
  logic                        s_valid_i;
  logic                        s_last_i;
  logic                        s_ready_o;
  logic                        ram_we_o;
  logic                        ram_sel_o;
  logic [BUFFER_ADDR_BITS-1:0] ram_addr_o;
  logic [7:0]                  ram_data_o;
  logic                        codec_buffer_filled_o;
  logic                        codec_buffer_empty_i;
  logic                        codec_buffer_empty_ack_o;
  logic                        done_o;

  always #5 clk = ~clk;

  buffer_filler dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start_i                  (start_i),
    .abort_i                  (abort_i),
    .s_data_i                 (s_data_i),
    .s_valid_i                (s_valid_i),
    .s_last_i                 (s_last_i),
    .s_ready_o                (s_ready_o),
    .ram_we_o                 (ram_we_o),
    .ram_sel_o                (ram_sel_o),
    .ram_addr_o               (ram_addr_o),
    .ram_data_o               (ram_data_o),
    .codec_buffer_filled_o    (codec_buffer_filled_o),
    .codec_buffer_empty_i     (codec_buffer_empty_i),
    .codec_buffer_empty_ack_o (codec_buffer_empty_ack_o),
    .done_o                   (done_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // RAM model and write log.
  logic [7:0] mem [0:1023];
  int         wr_log [0:4095];
  int         wr_cnt  = 0;
  int         ack_cnt = 0;
  int         bad_we  = 0;

  always @(posedge clk) begin
    if (ram_we_o) begin
      mem[{ram_sel_o, ram_addr_o}] <= ram_data_o;
      if (wr_cnt < 4096) wr_log[wr_cnt] <= 32'({ram_sel_o, ram_addr_o});
      wr_cnt <= wr_cnt + 1;
      if ((s_ready_o && !s_valid_i) || (!s_ready_o && ram_data_o != 8'h00))
        bad_we <= bad_we + 1;
    end
    if (codec_buffer_empty_ack_o) ack_cnt <= ack_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sends n bytes, byte k = base + 3k; s_last on the final byte if asked.
  task automatic stream(input int n, input bit last_at_end, input bit bp,
                        input logic [7:0] base);
    int sent = 0;
    int cycles = 0;
    while (sent < n && cycles < 5000) begin
      s_valid_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = base + 8'(sent * 3);
      s_last_i  = last_at_end && (sent == n - 1);
      #1;
      if (s_valid_i && s_ready_o) sent++;
      cyc();
      cycles++;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  // Verifies one half-buffer's contents and that its 512 writes came in
  // address order starting at log index log0.
  task automatic check_buf(input string tag, input logic sel, input logic [7:0] base,
                           input int nbytes, input int log0);
    int bad_d = 0;
    int bad_o = 0;
    logic [9:0] a;
    logic [7:0] e;
    for (int i = 0; i < 512; i++) begin
      a = {sel, 9'(i)};
      e = (i < nbytes) ? base + 8'(i * 3) : 8'h00;
      if (mem[a] !== e) bad_d++;
      if (wr_log[log0 + i] != 32'(a)) bad_o++;
    end
    chk({tag, "_data"}, bad_d, 0);
    chk({tag, "_order"}, bad_o, 0);
  endtask

  int w0, w1, a0, p;

  initial begin
    rst_n = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    s_data_i = 8'h00; s_valid_i = 1'b0; s_last_i = 1'b0;
    codec_buffer_empty_i = 1'b0;
    cyc(); cyc();

    // Reset state
    chk("rst_ready",  32'(s_ready_o), 0);
    chk("rst_we",     32'(ram_we_o), 0);
    chk("rst_sel",    32'(ram_sel_o), 1);
    chk("rst_addr",   32'(ram_addr_o), 0);
    chk("rst_filled", 32'(codec_buffer_filled_o), 0);
    chk("rst_ack",    32'(codec_buffer_empty_ack_o), 0);
    chk("rst_done",   32'(done_o), 0);

    // Start-up release held two cycles -> one ack
    rst_n = 1'b1;
    cyc();
    codec_buffer_empty_i = 1'b1;
    cyc();
    chk("startup_ack_pulse", 32'(codec_buffer_empty_ack_o), 1);
    cyc();
    codec_buffer_empty_i = 1'b0;
    cyc();
    chk("startup_ack_cnt", ack_cnt, 1);
    chk("idle_ready", 32'(s_ready_o), 0);

    // Full 512-byte fill into sel=1
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("start_ready", 32'(s_ready_o), 1);
    chk("start_sel",   32'(ram_sel_o), 1);
    w0 = wr_cnt;
    stream(512, 1'b0, 1'b0, 8'h10);
    chk("fill1_filled", 32'(codec_buffer_filled_o), 1);
    chk("fill1_ready",  32'(s_ready_o), 0);
    chk("fill1_writes", wr_cnt - w0, 512);
    check_buf("fill1", 1'b1, 8'h10, 512, w0);
    cyc(); cyc(); cyc();
    chk("full_hold_filled", 32'(codec_buffer_filled_o), 1);
    chk("full_no_we",       32'(ram_we_o), 0);
    chk("full_no_ack",      ack_cnt, 1);

    // Swap: release held two cycles
    codec_buffer_empty_i = 1'b1;
    cyc();
    chk("swap_ack",    32'(codec_buffer_empty_ack_o), 1);
    chk("swap_filled", 32'(codec_buffer_filled_o), 0);
    chk("swap_sel",    32'(ram_sel_o), 0);
    chk("swap_addr",   32'(ram_addr_o), 0);
    chk("swap_ready",  32'(s_ready_o), 1);
    cyc();
    codec_buffer_empty_i = 1'b0;
    chk("swap_ack_drop", 32'(codec_buffer_empty_ack_o), 0);
    chk("swap_ack_cnt",  ack_cnt, 2);

    // Short file, 100 bytes with backpressure, then padding
    w0 = wr_cnt;
    stream(100, 1'b1, 1'b1, 8'h80);
    chk("pad_ready", 32'(s_ready_o), 0);
    chk("pad_addr",  32'(ram_addr_o), 100);
    p = 0;
    while (!codec_buffer_filled_o && p < 1000) begin
      cyc();
      p++;
    end
    chk("pad_cycles",  p, 412);
    chk("pad_writes",  wr_cnt - w0, 512);
    chk("bp_bad_we",   bad_we, 0);
    check_buf("short", 1'b0, 8'h80, 100, w0);

    // Release with eof -> DONE
    codec_buffer_empty_i = 1'b1;
    cyc();
    codec_buffer_empty_i = 1'b0;
    chk("eof_done",   32'(done_o), 1);
    chk("eof_ack",    32'(codec_buffer_empty_ack_o), 1);
    chk("eof_filled", 32'(codec_buffer_filled_o), 0);
    chk("eof_sel",    32'(ram_sel_o), 1);
    cyc();
    chk("done_hold",  32'(done_o), 1);
    chk("done_ready", 32'(s_ready_o), 0);

    // Boundary: s_last on byte 512, release held during the fill
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("restart_sel",  32'(ram_sel_o), 0);
    chk("restart_done", 32'(done_o), 0);
    chk("restart_addr", 32'(ram_addr_o), 0);
    codec_buffer_empty_i = 1'b1;
    a0 = ack_cnt;
    w0 = wr_cnt;
    stream(512, 1'b1, 1'b0, 8'h33);
    chk("bnd_filled",     32'(codec_buffer_filled_o), 1);
    chk("bnd_no_pad_we",  32'(ram_we_o), 0);
    chk("bnd_fill_noack", ack_cnt - a0, 0);
    cyc();
    codec_buffer_empty_i = 1'b0;
    chk("bnd_ack",    32'(codec_buffer_empty_ack_o), 1);
    chk("bnd_done",   32'(done_o), 1);
    chk("bnd_writes", wr_cnt - w0, 512);
    check_buf("bnd", 1'b0, 8'h33, 512, w0);

    // Abort mid-fill at addr 37
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    stream(37, 1'b0, 1'b0, 8'h01);
    chk("abort_pre_addr", 32'(ram_addr_o), 37);
    s_valid_i = 1'b1;
    s_data_i  = 8'hff;
    abort_i   = 1'b1;
    #1;
    chk("abort_cycle_we",    32'(ram_we_o), 0);
    chk("abort_cycle_ready", 32'(s_ready_o), 0);
    cyc();
    abort_i = 1'b0;
    w1 = wr_cnt;
    chk("abort_ready",  32'(s_ready_o), 0);
    chk("abort_filled", 32'(codec_buffer_filled_o), 0);
    cyc(); cyc(); cyc();
    chk("abort_no_wr", wr_cnt - w1, 0);
    s_valid_i = 1'b0;

    // Reset in FULL
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    stream(512, 1'b0, 1'b0, 8'h44);
    chk("pre_rst_filled", 32'(codec_buffer_filled_o), 1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rst_full_filled", 32'(codec_buffer_filled_o), 0);
    chk("rst_full_sel",    32'(ram_sel_o), 1);

    // Reset in FILL
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    stream(10, 1'b0, 1'b0, 8'h55);
    s_valid_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_fill_we", 32'(ram_we_o), 0);
    cyc();
    rst_n = 1'b1;
    s_valid_i = 1'b0;
    chk("rst_fill_ready", 32'(s_ready_o), 0);
    chk("rst_fill_addr",  32'(ram_addr_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
